// File: rtl/target_generator.sv
// Food/target coordinate generator for the 160x120 snake grid: free-running LFSRs
// feed rejection sampling, with a bounded fold-back so a target always appears.
module target_generator #(
    parameter int unsigned MAX_X     = 159,
    parameter int unsigned MAX_Y     = 119,
    parameter logic [7:0]  INIT_X    = 8'd40,
    parameter logic [6:0]  INIT_Y    = 7'd30,
    parameter logic [7:0]  SEED_X    = 8'hA5,
    parameter logic [6:0]  SEED_Y    = 7'h3B,
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_State,
    input  logic       REACHED_TARGET,
    output logic [7:0] Random_Target_Address_X,
    output logic [6:0] Random_Target_Address_Y,
    output logic       TARGET_VALID
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [1:0] MSM_IDLE = 2'b00;
    localparam logic [1:0] MSM_PLAY = 2'b01;

    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
    localparam logic [7:0]       LIM_X    = 8'(MAX_X);
    localparam logic [6:0]       LIM_Y    = 7'(MAX_Y);
    localparam logic [8:0]       MOD_X    = 9'(MAX_X + 1);
    localparam logic [7:0]       MOD_Y    = 8'(MAX_Y + 1);

    logic [1:0]       state;
    logic [7:0]       lfsr_x;
    logic [6:0]       lfsr_y;
    logic             reached_q;
    logic [TRY_W-1:0] try_cnt;

    logic             rt_rise;
    logic             accept;
    logic             fold_hit;
    logic [7:0]       fold_x;
    logic [6:0]       fold_y;
    logic [7:0]       forced_x;

    assign rt_rise = REACHED_TARGET & ~reached_q;

    assign accept = (lfsr_x <= LIM_X) && (lfsr_y <= LIM_Y) &&
                    ((lfsr_x != Random_Target_Address_X) || (lfsr_y != Random_Target_Address_Y));

    // A modulo equals the single subtract-fold on the full grid, and still keeps
    // the result in range when the grid limits are overridden to something tiny.
    assign fold_x   = 8'({1'b0, lfsr_x} % MOD_X);
    assign fold_y   = 7'({1'b0, lfsr_y} % MOD_Y);
    assign fold_hit = (fold_x == Random_Target_Address_X) && (fold_y == Random_Target_Address_Y);
    assign forced_x = !fold_hit          ? fold_x :
                      (fold_x == LIM_X)  ? 8'd0   : fold_x + 8'd1;

    assign TARGET_VALID = (state == ST_HOLD);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state                   <= ST_IDLE;
            lfsr_x                  <= SEED_X;
            lfsr_y                  <= SEED_Y;
            reached_q               <= 1'b0;
            try_cnt                 <= '0;
            Random_Target_Address_X <= INIT_X;
            Random_Target_Address_Y <= INIT_Y;
        end else begin
            lfsr_x    <= {lfsr_x[6:0], lfsr_x[7] ^ lfsr_x[5] ^ lfsr_x[4] ^ lfsr_x[3]};
            lfsr_y    <= {lfsr_y[5:0], lfsr_y[6] ^ lfsr_y[5]};
            reached_q <= REACHED_TARGET;

            // Leaving play always wins over a pending accept or head-on-target event.
            case (state)
                ST_IDLE: begin
                    if (MSM_State == MSM_PLAY) begin
                        state   <= ST_SEARCH;
                        try_cnt <= '0;
                    end else if (MSM_State == MSM_IDLE) begin
                        Random_Target_Address_X <= INIT_X;
                        Random_Target_Address_Y <= INIT_Y;
                    end
                end
                ST_SEARCH: begin
                    if (MSM_State != MSM_PLAY) begin
                        state <= ST_IDLE;
                    end else if (accept) begin
                        Random_Target_Address_X <= lfsr_x;
                        Random_Target_Address_Y <= lfsr_y;
                        state                   <= ST_HOLD;
                    end else if (try_cnt == LAST_TRY) begin
                        Random_Target_Address_X <= forced_x;
                        Random_Target_Address_Y <= fold_y;
                        state                   <= ST_HOLD;
                    end else begin
                        try_cnt <= try_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (MSM_State != MSM_PLAY) begin
                        state <= ST_IDLE;
                    end else if (rt_rise) begin
                        state   <= ST_SEARCH;
                        try_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
